uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares one serial transmit line among `NREQ` byte producers. It sits downstream of the baud rate generator and consumes its 16x-oversampling `tick` pulse. A round-robin grant selects which requester owns the next frame. The block then serializes that byte as a standard 8N1 UART frame on `tx`.

## Interface
- `NREQ`, 4: number of requesters, ≥2
- `DBIT`, 8: data bits per frame
- `OVS`, 16: ticks per bit (start and data bits)
- `SB_TICK`, 16: ticks in the stop bit
- `clk`  in  1  system clock
- `rst`  in  1  reset: one clock; reset is synchronous and active-high
- `tick`  in  1  one-cycle baud pulse at 16x baud, from the baud rate generator
- `req_valid`  in  NREQ  per-requester byte available; held until accepted
- `req_data`  in  NREQ*DBIT  byte of requester i at bits [i*DBIT +: DBIT]
- `req_ready`  out  NREQ  one-hot, one-cycle accept pulse to the granted requester
- `tx`  out  1  serial line, idle high
- `busy`  out  1  high from the cycle after accept until the frame ends
- `grant_id`  out  $clog2(NREQ)  index of the current or last frame owner

## Operation
- FSM states: IDLE, START, DATA, STOP.
- IDLE
  - `tx`=1 and `busy`=0.
  - If any `req_valid` is high, the round-robin search starts at `ptr+1` mod NREQ and takes the first valid index i.
  - In the same cycle: `req_ready[i]`=1, `req_data` slice i is latched into the shift register, `ptr`<=i, `grant_id`<=i.
  - Next state is START, with `tick_cnt`=0.
- START
  - `tx`=0.
  - On each `tick`, `tick_cnt` increments.
  - On a `tick` while `tick_cnt`==OVS-1: `tick_cnt`<=0, `bit_cnt`<=0, next state DATA.
- DATA
  - `tx`=shreg[0], so data goes out LSB first.
  - On a `tick` while `tick_cnt`==OVS-1: shift right and increment `bit_cnt`.
  - When `bit_cnt`==DBIT-1 at that point, next state is STOP.
- STOP
  - `tx`=1.
  - On a `tick` while `tick_cnt`==SB_TICK-1: next state IDLE.
- Arbitration happens only in IDLE, so there is at least one clock of idle between frames. A requester holding `req_valid` is served within NREQ frames.
- `tick` in IDLE is ignored. `tick_cnt` does not run in IDLE.
- If `req_valid` drops before accept, no grant is made and no frame is sent. Data is sampled only in the accept cycle.
- Counter widths:
  - `tick_cnt`: $clog2(max(OVS,SB_TICK)) bits.
  - `bit_cnt`: $clog2(DBIT) bits.
  - `ptr`: $clog2(NREQ) bits, with explicit wrap at NREQ-1 (NREQ need not be a power of 2).

## Timing
- Reset values: `tx`=1, `busy`=0, `req_ready`=0, `grant_id`=0, state=IDLE, `ptr`=NREQ-1 (so requester 0 is first after reset).
- Accept latency: `req_ready` is asserted in the first cycle in IDLE with a valid request.
  - The `req_ready` output is combinational from `req_valid` and `ptr` while in IDLE.
  - All other outputs are registered.
- `tx` falls in the cycle after accept. The start bit is therefore 16 ticks from accept; its first tick may be up to one tick period late.
- Frame length is (1+DBIT)*OVS+SB_TICK ticks, i.e. 160 ticks at the defaults.
- `rst` asserted mid-frame:
  - Next edge: `tx`=1, `busy`=0, state IDLE, `ptr`=NREQ-1.
  - The partial frame is aborted and not retried. The requester was already acked.

## Structure
- Package `uart_pkg`:
  - `tx_state_t` enum {IDLE, START, DATA, STOP}.
  - Default constants for DBIT, OVS, SB_TICK.
- Sub-module `uart_rr_arbiter`:
  - Inputs: `req` vector and `ptr`.
  - Outputs: one-hot `gnt` and `gnt_id`.
  - Purely combinational.
  - The top level owns `ptr`, the FSM, the counters and the shift register.

## Test plan
- **Reset state:** reset with all `req_valid`=0 → `tx`=1, `busy`=0, `req_ready`=0 for 100 cycles, even while `tick` toggles.
- **Single byte:** `req_valid[2]`=1 with data 0xA5, `tick` every 4 cycles → one `req_ready[2]` pulse, `grant_id`=2.
  - `tx` sequence per 16 ticks: 0, 1,0,1,0,0,1,0,1, 1.
  - `busy` is high for exactly 160 ticks.
- **Round robin:** all four requesters valid continuously with data 0x10..0x13 → grant order 0,1,2,3,0,…; frames carry 0x10,0x11,0x12,0x13.
- **Fairness wrap:** only requesters 3 and 1 valid, last grant was 3 → next grants are 1, then 3, then 1.
- **Reset mid-frame:** assert `rst` during DATA bit 4 → `tx`=1 at the next edge. After release, with requesters 1 and 3 valid, requester 1 is granted first.
- **Withdrawn request:** `req_valid[0]` pulses for 1 cycle while `busy`=1 → no `req_ready[0]`, and no extra frame after the current one ends.

Source files
------------

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and default constants for the arbitrated UART transmitter.
//   tx_state_t   : transmit FSM states
//   *_DEF        : default requester count, data bits, ticks per bit, stop ticks
//   max_int()    : elaboration-time helper for sizing counters
// -----------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } tx_state_t;

   localparam int NREQ_DEF    = 4;
   localparam int DBIT_DEF    = 8;
   localparam int OVS_DEF     = 16;
   localparam int SB_TICK_DEF = 16;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_if
// Bundle of the producer handshake, baud tick and serial-side status signals.
//   tick      : 16x baud pulse from the baud rate generator
//   req_valid : per-requester byte available, held until accepted
//   req_data  : byte of requester i at [i*DBIT +: DBIT]
//   req_ready : one-hot, one-cycle accept pulse
//   tx        : serial line, idle high
//   busy      : frame in progress
//   grant_id  : index of the current or last frame owner
// Modports: master = producers/environment side, slave = transmitter side.
// -----------------------------------------------------------------------------
interface uart_tx_arbiter_if
   import uart_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   parameter int DBIT = DBIT_DEF
);

   logic                     tick;
   logic [NREQ-1:0]          req_valid;
   logic [NREQ*DBIT-1:0]     req_data;
   logic [NREQ-1:0]          req_ready;
   logic                     tx;
   logic                     busy;
   logic [$clog2(NREQ)-1:0]  grant_id;

   modport master (
      output tick, req_valid, req_data,
      input  req_ready, tx, busy, grant_id
   );

   modport slave (
      input  tick, req_valid, req_data,
      output req_ready, tx, busy, grant_id
   );

endinterface

// File: rtl/uart_rr_arbiter.sv
// -----------------------------------------------------------------------------
// uart_rr_arbiter
// Purely combinational round-robin picker. The search starts one past the
// last owner and wraps explicitly at NREQ-1, so NREQ need not be a power of 2.
//   req    : request vector
//   ptr    : index of the last granted requester
//   gnt    : one-hot grant (all zero when nothing requests)
//   gnt_id : index of the granted requester
// -----------------------------------------------------------------------------
module uart_rr_arbiter #(
   parameter int NREQ = 4,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] gnt,
   output logic [IDW-1:0]  gnt_id
);

   always_comb begin
      logic           found;
      logic [IDW-1:0] idx;
      // NOTE: every output of a combinational block gets a default before any
      // conditional assignment; a path that leaves it unassigned infers a latch.
      gnt    = '0;
      gnt_id = '0;
      found  = 1'b0;
      idx    = '0;
      // Offsets 1..NREQ visit every requester once, ending at ptr itself.
      for (int k = 1; k <= NREQ; k++) begin
         idx = IDW'((int'(ptr) + k) % NREQ);
         if (!found && req[idx]) begin
            found    = 1'b1;
            gnt[idx] = 1'b1;
            gnt_id   = idx;
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
// Shares one 8N1 UART transmit line among NREQ byte producers. In IDLE a
// round-robin grant accepts one byte (req_ready is combinational there); the
// byte is then sent LSB first: start bit, DBIT data bits, one stop bit, each
// timed in baud ticks. tx, busy and grant_id are registered.
//   clk : system clock
//   rst : synchronous, active-high reset
//   bus : uart_tx_arbiter_if.slave (tick, req_*, tx, busy, grant_id)
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int DBIT    = DBIT_DEF,
   parameter int OVS     = OVS_DEF,
   parameter int SB_TICK = SB_TICK_DEF
) (
   input  logic               clk,
   input  logic               rst,
   uart_tx_arbiter_if.slave   bus
);

   localparam int IDW = $clog2(NREQ);
   localparam int TW  = $clog2(max_int(OVS, SB_TICK));
   localparam int BW  = $clog2(DBIT);

   tx_state_t        state_q, state_d;
   logic [TW-1:0]    tick_cnt_q, tick_cnt_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [DBIT-1:0]  shreg_q, shreg_d;
   logic [IDW-1:0]   ptr_q, ptr_d;
   logic [IDW-1:0]   grant_id_q, grant_id_d;
   logic             tx_q, tx_d;
   logic             busy_q, busy_d;

   logic [NREQ-1:0]  gnt;
   logic [IDW-1:0]   gnt_id;
   logic             any_gnt;
   logic             bit_end;
   logic             stop_end;
   logic             last_data_bit;

   uart_rr_arbiter #(.NREQ(NREQ)) u_arb (
      .req    (bus.req_valid),
      .ptr    (ptr_q),
      .gnt    (gnt),
      .gnt_id (gnt_id)
   );

   assign any_gnt       = |gnt;
   assign bit_end       = bus.tick && (tick_cnt_q == TW'(OVS - 1));
   assign stop_end      = bus.tick && (tick_cnt_q == TW'(SB_TICK - 1));
   assign last_data_bit = (bit_cnt_q == BW'(DBIT - 1));

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking (<=) so every register samples
      // pre-edge values regardless of statement order.
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (any_gnt)                  state_d = START;
         START:   if (bit_end)                  state_d = DATA;
         DATA:    if (bit_end && last_data_bit) state_d = STOP;
         STOP:    if (stop_end)                 state_d = IDLE;
         default:                               state_d = IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   // tx/busy are computed from the next state so the registered copies line up
   // with state_q; tx therefore falls in the cycle after accept.
   always_comb begin
      tx_d   = 1'b1;
      busy_d = 1'b0;
      case (state_d)
         START: begin
            tx_d   = 1'b0;
            busy_d = 1'b1;
         end
         DATA: begin
            tx_d   = shreg_d[0];
            busy_d = 1'b1;
         end
         STOP:    busy_d = 1'b1;
         default: ;
      endcase
   end

   // Accept pulse is only meaningful in IDLE; it is masked while in reset so no
   // requester sees an ack that the datapath will discard.
   assign bus.req_ready = (state_q == IDLE && !rst) ? gnt : '0;
   assign bus.tx        = tx_q;
   assign bus.busy      = busy_q;
   assign bus.grant_id  = grant_id_q;

   // ----------------------------------------------------------------- datapath
   always_comb begin
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shreg_d    = shreg_q;
      ptr_d      = ptr_q;
      grant_id_d = grant_id_q;
      case (state_q)
         // Ticks are ignored here; tick_cnt only restarts on accept.
         IDLE: begin
            if (any_gnt) begin
               shreg_d    = bus.req_data[gnt_id*DBIT +: DBIT];
               ptr_d      = gnt_id;
               grant_id_d = gnt_id;
               tick_cnt_d = '0;
            end
         end
         START: begin
            if (bit_end) begin
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
            end else if (bus.tick) begin
               tick_cnt_d = tick_cnt_q + TW'(1);
            end
         end
         DATA: begin
            if (bit_end) begin
               tick_cnt_d = '0;
               shreg_d    = shreg_q >> 1;
               bit_cnt_d  = bit_cnt_q + BW'(1);
            end else if (bus.tick) begin
               tick_cnt_d = tick_cnt_q + TW'(1);
            end
         end
         STOP: begin
            if (stop_end)      tick_cnt_d = '0;
            else if (bus.tick) tick_cnt_d = tick_cnt_q + TW'(1);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         ptr_q      <= IDW'(NREQ - 1);
         grant_id_q <= '0;
         tx_q       <= 1'b1;
         busy_q     <= 1'b0;
      end else begin
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         ptr_q      <= ptr_d;
         grant_id_q <= grant_id_d;
         tx_q       <= tx_d;
         busy_q     <= busy_d;
      end
   end

   // NOTE: the shift register is pure data, always loaded before use, so it is
   // left without reset.
   always_ff @(posedge clk) begin
      shreg_q <= shreg_d;
   end

endmodule
